// File: rtl/slot_arbiter_if.sv
// slot_arbiter_if: bundle between requester blocks and the time-slot arbiter.
//   req        : per-requester request level (requester side drives)
//   gnt        : one-hot grant, all-zero when idle
//   gnt_id     : index of the current holder (holds last holder when idle)
//   busy       : high whenever gnt is non-zero
//   slot_count : phase within the current slot, 0 when idle
//   slot_done  : one-cycle pulse after any slot termination edge
// Handshake: req is a level, not a valid/ready pulse. A requester raises req
// and keeps it high while it wants the resource. It owns the resource in every
// cycle where its gnt bit is high. Dropping req ends the grant at the next edge.
interface slot_arbiter_if #(
  parameter int NREQ = 4,
  parameter int MOD  = 6
) ();
  localparam int CW = $clog2(MOD);
  localparam int IW = $clog2(NREQ);

  logic [NREQ-1:0] req;
  logic [NREQ-1:0] gnt;
  logic [IW-1:0]   gnt_id;
  logic            busy;
  logic [CW-1:0]   slot_count;
  logic            slot_done;

  modport master (
    output req,
    input  gnt, gnt_id, busy, slot_count, slot_done
  );

  modport slave (
    input  req,
    output gnt, gnt_id, busy, slot_count, slot_done
  );
endinterface

// File: rtl/slot_arbiter.sv
// slot_arbiter: round-robin time-slot arbiter over a shared mod-MOD slot counter.
// Ports:
//   clk         : clock, all updates on posedge
//   rst         : asynchronous active-high reset
//   bus         : slot_arbiter_if slave modport (req in; gnt/gnt_id/busy/
//                 slot_count/slot_done out, all registered)
//   dbg_grant_o : FSM state observation, 1 while in GRANT
module slot_arbiter #(
  parameter int NREQ = 4,
  parameter int MOD  = 6
) (
  input  logic          clk,
  input  logic          rst,
  slot_arbiter_if.slave bus,
  output logic          dbg_grant_o
);
  localparam int CW = $clog2(MOD);
  localparam int IW = $clog2(NREQ);

  typedef enum logic {IDLE, GRANT} state_e;

  state_e          state_q;
  logic [NREQ-1:0] gnt_q;
  logic [IW-1:0]   gnt_id_q;
  logic [IW-1:0]   ptr_q;
  logic            busy_q;
  logic [CW-1:0]   cnt_q;
  logic            slot_done_q;

  logic [IW-1:0]   ptr_d;
  logic [IW-1:0]   arb_ptr;
  logic            term;
  logic            win_found;
  logic [IW-1:0]   win_idx;
  logic [IW-1:0]   cand;
  int              k;

  always_comb begin
    // Pointer after the current holder, wrapped explicitly (NREQ may not be 2^n).
    ptr_d = (gnt_id_q == IW'(NREQ - 1)) ? '0 : gnt_id_q + 1'b1;
    term  = (state_q == GRANT) &&
            ((cnt_q == CW'(MOD - 1)) || !bus.req[gnt_id_q]);
    // At a termination edge arbitration already uses the advanced pointer,
    // so the outgoing holder has lowest priority.
    arb_ptr   = (state_q == GRANT) ? ptr_d : ptr_q;
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    k         = 0;
    for (int i = 0; i < NREQ; i++) begin
      k = int'(arb_ptr) + i;
      if (k >= NREQ) k = k - NREQ;
      cand = IW'(k);
      if (!win_found && bus.req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      gnt_id_q    <= '0;
      ptr_q       <= '0;
      busy_q      <= 1'b0;
      cnt_q       <= '0;
      slot_done_q <= 1'b0;
    end else begin
      slot_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (win_found) begin
            state_q  <= GRANT;
            gnt_q    <= NREQ'(1) << win_idx;
            gnt_id_q <= win_idx;
            busy_q   <= 1'b1;
            cnt_q    <= '0;
          end
        end
        GRANT: begin
          if (term) begin
            ptr_q       <= ptr_d;
            slot_done_q <= 1'b1;
            cnt_q       <= '0;
            if (win_found) begin
              gnt_q    <= NREQ'(1) << win_idx;
              gnt_id_q <= win_idx;
            end else begin
              state_q <= IDLE;
              gnt_q   <= '0;
              busy_q  <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.gnt        = gnt_q;
  assign bus.gnt_id     = gnt_id_q;
  assign bus.busy       = busy_q;
  assign bus.slot_count = cnt_q;
  assign bus.slot_done  = slot_done_q;
  assign dbg_grant_o    = (state_q == GRANT);
endmodule
